// File: rtl/btn_event_pkg.sv
// Shared types and defaults for the button gesture classifier.
// Holds the FSM state encoding and default tick settings.
package btn_event_pkg;

    localparam int DEF_N          = 24;
    localparam int DEF_LONG_TICKS = 10;
    localparam int DEF_DBL_TICKS  = 8;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESSED      = 3'd1,
        LONG_HELD    = 3'd2,
        WAIT_SECOND  = 3'd3,
        SECOND_PRESS = 3'd4
    } state_t;

endpackage

// File: rtl/btn_tick_timer.sv
// Saturating tick counter with equal / greater-or-equal compare.
// A clear together with inc loads 1, so a new press starts counting at once.
module btn_tick_timer #(
    parameter int N = 24
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clear,
    input  logic         i_inc,
    input  logic [N-1:0] i_limit,
    output logic         o_eq,
    output logic         o_ge
);

    logic [N-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = &r_cnt;
    assign o_eq  = (r_cnt == i_limit);
    assign o_ge  = (r_cnt >= i_limit);

    // Counter: clear/load has priority, increment stops at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= i_inc ? N'(1) : '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + N'(1);
        end
    end

endmodule

// File: rtl/btn_event_fsm.sv
// Classifies a debounced button into press/release, short, long and
// double-click events; every output is registered.
module btn_event_fsm
    import btn_event_pkg::*;
#(
    parameter int N           = DEF_N,
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic         sysclk,
    input  logic         reset_n,
    input  logic         btn_i,
    input  logic [N-1:0] long_ticks,
    input  logic [N-1:0] dbl_ticks,
    output logic         press_o,
    output logic         release_o,
    output logic         short_o,
    output logic         long_o,
    output logic         double_o,
    output logic         held_o
);

    state_t       r_state;
    state_t       w_state_nx;
    logic         r_btn_q;
    logic         w_act;
    logic         w_rise;
    logic         w_fall;
    logic         w_clr;
    logic         w_inc;
    logic         w_short;
    logic         w_long;
    logic         w_double;
    logic         w_eq;
    logic         w_ge;
    logic [N-1:0] w_limit;

    assign w_act  = ~(btn_i ^ ACTIVE_HIGH);
    assign w_rise = w_act & ~r_btn_q;
    assign w_fall = ~w_act & r_btn_q;

    // Only the double-click window compares against dbl_ticks.
    assign w_limit = (r_state == WAIT_SECOND) ? dbl_ticks : long_ticks;

    btn_tick_timer #(
        .N (N)
    ) u_timer (
        .i_clk   (sysclk),
        .i_rst_n (reset_n),
        .i_clear (w_clr),
        .i_inc   (w_inc),
        .i_limit (w_limit),
        .o_eq    (w_eq),
        .o_ge    (w_ge)
    );

    // Previous active level for edge detection.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= w_act;
        end
    end

    // State register.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state, timer control and event strobes.
    always_comb begin
        w_state_nx = r_state;
        w_clr      = 1'b0;
        w_inc      = 1'b0;
        w_short    = 1'b0;
        w_long     = 1'b0;
        w_double   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nx = PRESSED;
                    w_clr      = 1'b1;
                    w_inc      = 1'b1;
                end
            end
            PRESSED: begin
                if (w_act) begin
                    if ((long_ticks != '0) && w_eq) begin
                        w_long     = 1'b1;
                        w_state_nx = LONG_HELD;
                    end else begin
                        w_inc = 1'b1;
                    end
                end else begin
                    w_state_nx = WAIT_SECOND;
                    w_clr      = 1'b1;
                end
            end
            LONG_HELD: begin
                if (w_fall) begin
                    w_state_nx = IDLE;
                end
            end
            WAIT_SECOND: begin
                if (w_rise) begin
                    w_double   = 1'b1;
                    w_state_nx = SECOND_PRESS;
                end else if (w_ge) begin
                    w_short    = 1'b1;
                    w_state_nx = IDLE;
                end else begin
                    w_inc = 1'b1;
                end
            end
            SECOND_PRESS: begin
                if (w_fall) begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Registered outputs; held_o follows the state being entered.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            short_o   <= 1'b0;
            long_o    <= 1'b0;
            double_o  <= 1'b0;
            held_o    <= 1'b0;
        end else begin
            press_o   <= w_rise;
            release_o <= w_fall;
            short_o   <= w_short;
            long_o    <= w_long;
            double_o  <= w_double;
            held_o    <= (w_state_nx == LONG_HELD);
        end
    end

endmodule

// File: tb/tb_btn_event_fsm.sv
// Scoreboard bench for btn_event_fsm: an active-high and an active-low
// instance see the same gestures and must produce identical events.
module tb_btn_event_fsm;

    localparam int N = 24;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_SHORT = 2;
    localparam int K_LONG  = 3;
    localparam int K_DBL   = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic         sysclk = 1'b0;
    logic         reset_n;
    logic         btn;
    logic         btn_n;
    logic [N-1:0] long_ticks;
    logic [N-1:0] dbl_ticks;

    logic p1, r1, s1, l1, d1, h1;
    logic p0, r0, s0, l0, d0, h0;
    logic [4:0] ev1, ev0;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  q0[$];
    ev_t  q1[$];

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    assign btn_n = ~btn;
    assign ev1 = {d1, l1, s1, r1, p1};
    assign ev0 = {d0, l0, s0, r0, p0};

    btn_event_fsm #(.N(N), .ACTIVE_HIGH(1'b1)) u_hi (
        .sysclk     (sysclk),
        .reset_n    (reset_n),
        .btn_i      (btn),
        .long_ticks (long_ticks),
        .dbl_ticks  (dbl_ticks),
        .press_o    (p1),
        .release_o  (r1),
        .short_o    (s1),
        .long_o     (l1),
        .double_o   (d1),
        .held_o     (h1)
    );

    btn_event_fsm #(.N(N), .ACTIVE_HIGH(1'b0)) u_lo (
        .sysclk     (sysclk),
        .reset_n    (reset_n),
        .btn_i      (btn_n),
        .long_ticks (long_ticks),
        .dbl_ticks  (dbl_ticks),
        .press_o    (p0),
        .release_o  (r0),
        .short_o    (s0),
        .long_o     (l0),
        .double_o   (d0),
        .held_o     (h0)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic expect_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        q0.push_back(e);
        q1.push_back(e);
    endtask

    task automatic pop_cmp(input int d, input int k);
        ev_t e;
        int  have;
        checks++;
        have = (d == 0) ? q0.size() : q1.size();
        if (have == 0) begin
            failures++;
            $display("FAIL sb_unexpected dut%0d got kind=%0d cyc=%0d expected none",
                     d, k, cyc);
        end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                failures++;
                $display("FAIL sb_event dut%0d got kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
                         d, k, cyc, e.kind, e.cyc);
            end
        end
    endtask

    // Monitor: every output pulse consumes the oldest expected event.
    always @(negedge sysclk) begin
        for (int k = 0; k < 5; k++) begin
            if (ev1[k]) pop_cmp(1, k);
            if (ev0[k]) pop_cmp(0, k);
        end
    end

    task automatic chk(input string name, input logic [5:0] got,
                       input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b at cyc=%0d", name, got, exp, cyc);
        end
    endtask

    task automatic chk_held(input string name, input logic exp);
        chk({name, "_hi"}, {5'b0, h1}, {5'b0, exp});
        chk({name, "_lo"}, {5'b0, h0}, {5'b0, exp});
    endtask

    int t;
    int f;

    initial begin
        reset_n    = 1'b0;
        btn        = 1'b0;
        long_ticks = N'(10);
        dbl_ticks  = N'(8);
        tick(3);
        chk("reset_hi", {h1, ev1}, 6'b0);
        chk("reset_lo", {h0, ev0}, 6'b0);
        reset_n = 1'b1;
        tick(2);

        // Short click: high 3 cycles, short 9 cycles after the fall.
        t = cyc;
        expect_ev(K_PRESS, t + 1);
        expect_ev(K_REL,   t + 4);
        expect_ev(K_SHORT, t + 13);
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(20);

        // Long press: long 10 cycles after press, held until the fall.
        t = cyc;
        expect_ev(K_PRESS, t + 1);
        expect_ev(K_LONG,  t + 11);
        expect_ev(K_REL,   t + 31);
        btn = 1'b1;
        tick(10);
        chk_held("held_before_long", 1'b0);
        tick(1);
        chk_held("held_at_long", 1'b1);
        tick(19);
        chk_held("held_late", 1'b1);
        btn = 1'b0;
        tick(2);
        chk_held("held_after_rel", 1'b0);
        tick(15);

        // Double click: high 2, low 4, high 2.
        t = cyc;
        expect_ev(K_PRESS, t + 1);
        expect_ev(K_REL,   t + 3);
        expect_ev(K_PRESS, t + 7);
        expect_ev(K_DBL,   t + 7);
        expect_ev(K_REL,   t + 9);
        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        tick(4);
        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        tick(20);

        // Second rise exactly when the window count reaches dbl_ticks.
        t = cyc;
        f = t + 3;
        expect_ev(K_PRESS, t + 1);
        expect_ev(K_REL,   f);
        expect_ev(K_PRESS, f + 9);
        expect_ev(K_DBL,   f + 9);
        expect_ev(K_REL,   f + 11);
        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        tick(9);
        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        tick(20);

        // Second rise one cycle late: short, then a fresh press.
        t = cyc;
        f = t + 3;
        expect_ev(K_PRESS, t + 1);
        expect_ev(K_REL,   f);
        expect_ev(K_SHORT, f + 9);
        expect_ev(K_PRESS, f + 10);
        expect_ev(K_REL,   f + 12);
        expect_ev(K_SHORT, f + 21);
        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        tick(10);
        btn = 1'b1;
        tick(2);
        btn = 1'b0;
        tick(20);

        // long_ticks = 0: no long event, short after release.
        long_ticks = '0;
        t = cyc;
        expect_ev(K_PRESS, t + 1);
        expect_ev(K_REL,   t + 101);
        expect_ev(K_SHORT, t + 110);
        btn = 1'b1;
        tick(100);
        chk_held("held_long_off", 1'b0);
        btn = 1'b0;
        tick(15);
        long_ticks = N'(10);

        // dbl_ticks = 0: short one cycle after the release.
        dbl_ticks = '0;
        t = cyc;
        expect_ev(K_PRESS, t + 1);
        expect_ev(K_REL,   t + 4);
        expect_ev(K_SHORT, t + 5);
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(6);
        dbl_ticks = N'(8);

        // Reset while in LONG_HELD, released with the button still down.
        t = cyc;
        expect_ev(K_PRESS, t + 1);
        expect_ev(K_LONG,  t + 11);
        btn = 1'b1;
        tick(15);
        chk_held("held_pre_reset", 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_hi", {h1, ev1}, 6'b0);
        chk("async_reset_lo", {h0, ev0}, 6'b0);
        tick(3);
        t = cyc;
        expect_ev(K_PRESS, t + 1);
        expect_ev(K_REL,   t + 4);
        expect_ev(K_SHORT, t + 13);
        reset_n = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(20);

        checks++;
        if (q1.size() != 0) begin
            failures++;
            $display("FAIL sb_drain dut1 got pending=%0d expected 0", q1.size());
        end
        checks++;
        if (q0.size() != 0) begin
            failures++;
            $display("FAIL sb_drain dut0 got pending=%0d expected 0", q0.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
